sha512_pad: RTL and testbench
=============================

Name: sha512_pad

Overview:
- Upstream feeder for the SHA-512 wrapper.
- Accepts a message as a stream of 512-bit CCI-P read-response lines plus a byte length.
- Applies FIPS 180-4 padding (0x80 byte, zero fill, 128-bit big-endian bit length) and byte-swaps to big-endian.
- Hands 1024-bit blocks to the hash wrapper as block[2]/block_valid, pacing on its ready output.

Parameters:
- LEN_W, 32, width of message byte length; supported lengths 0 .. 2^LEN_W-1 bytes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse in IDLE; latches msg_len; ignored outside IDLE
- msg_len  in  LEN_W  message length in bytes
- line_data  in  512  message line; byte k of line at bits [8k+7:8k] (little-endian)
- line_valid  in  1  line_data valid
- line_ready  out  1  line accepted when line_valid && line_ready
- block  out  512 x2  block[1] = first 64 bytes of the 128-byte block, block[0] = last 64 bytes
- block_valid  out  1  one-cycle pulse; block stable from the pulse until next pulse
- core_ready  in  1  hash wrapper ready output
- last_block  out  1  high with block_valid on the final padded block
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. A reset asserted mid-message aborts it; no further block_valid is issued.
- Byte order: incoming line byte k maps to bits [511-8k -: 8] of the output half-line, so message byte 0 lands at block[1][511:504].
- Bookkeeping: remaining = msg_len, decremented by 64 per accepted line (saturating at 0). Lines expected = ceil(msg_len/64); msg_len=0 consumes no lines.
- Masking: in the last line, bytes at index >= remaining are replaced by padding.
  - The 0x80 byte goes at the first invalid byte position.
  - The remaining invalid bytes are 0x00.
- States:
  - IDLE: start -> FILL0.
  - FILL0: line_ready=1. Accept -> block[1]. Message exhausted and pad not yet placed -> place 0x80 here, no line consumed.
  - FILL1: same rules for block[0].
  - LEN: if the final-block condition holds, write {64'h0, bitlen} into block[0][127:0], with bitlen = {msg_len, 3'b000} zero-extended to 64 bits.
  - ISSUE: wait core_ready=1; pulse block_valid for 1 cycle -> WBUSY.
  - WBUSY: wait core_ready=0 (the wrapper drops ready 2 cycles after the pulse) -> WRDY.
  - WRDY: wait core_ready=1. If last_block was sent -> IDLE; else -> FILL0.
- Final-block condition: all message bytes consumed, 0x80 already placed, and the block's byte offset of the first free byte is <= 112.
  - r = msg_len mod 128.
  - r <= 111: 1 padded block at the end.
  - r >= 112: an extra all-pad block (0x80 already in the previous block, zeros plus length).
  - r = 0 with msg_len > 0: an extra block starting 0x80.
- Total blocks = floor((msg_len + 16)/128) + 1.
- line_ready is 0 outside FILL0/FILL1 and after all lines are consumed. Extra line_valid beyond the expected count is not accepted.
- When the message ends mid-line, a padding half-line is generated without waiting for line_valid.
- start in a non-IDLE state is ignored.

Optional Feature:
- SHA512_PAD_STATS_EN defined: adds outputs blk_count (32-bit, blocks issued since reset, increments on each block_valid, wraps at 2^32) and msg_count (32-bit, messages completed, increments on last_block pulse).
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- len=0, start -> no line_ready handshake; one block: block[1][511:504]=0x80, all other bytes 0, block[0][127:0]=0, last_block=1; downstream digest cf83e135...927da3e.
- len=3, line byte0..2 = 61 62 63 -> one block: block[1][511:480]=0x61626380, block[0][127:0]=0x18, last_block=1; digest ddaf35a1...a54ca49f.
- len=112, 2 lines of 0xAA -> two blocks:
  - first: bytes 0..111 = 0xAA, byte 112 = 0x80, bytes 113..127 = 0, last_block=0.
  - second: all zero except block[0][127:0]=0x380, last_block=1.
- len=128, 2 lines -> two blocks; second block[1][511:504]=0x80, length field 0x400.
- core_ready held 0 for 20 cycles before ISSUE, line_valid toggling 1/0 -> block_valid only while core_ready=1, exactly one pulse per block, no line lost or duplicated.
- reset asserted 1 cycle after the first line accept of a 3-line message -> next cycle all outputs 0, state IDLE; a fresh len=3 message afterwards hashes correctly.

Source files
------------

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs 512-bit little-endian lines into big-endian 1024-bit padded blocks.
// Optional SHA512_PAD_STATS_EN adds blk_count/msg_count statistics outputs.
module sha512_pad #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [511:0]     line_data,
  input  logic             line_valid,
  output logic             line_ready,
  output logic [511:0]     block [2],
  output logic             block_valid,
  input  logic             core_ready,
  output logic             last_block,
`ifdef SHA512_PAD_STATS_EN
  output logic [31:0]      blk_count,
  output logic [31:0]      msg_count,
`endif
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, FILL0, FILL1, LEN, ISSUE, WBUSY, WRDY} state_t;

  localparam logic [LEN_W-1:0] LINE_BYTES = LEN_W'(64);
  localparam logic [LEN_W-1:0] LATE_PAD   = LEN_W'(48);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, remaining_reg;
  logic             pad_placed_reg, late_pad_reg, final_reg;
  logic [511:0]     work1_reg, work0_reg, half_next;
  logic [511:0]     block1_reg, block0_reg;
  logic             block_valid_reg, last_block_reg;
  logic             fill, advance, fin, issue_fire;
  logic [63:0]      bitlen;

  assign fill       = (state_reg == FILL0) || (state_reg == FILL1);
  assign line_ready = fill && (remaining_reg != '0);
  assign advance    = fill && ((remaining_reg == '0) || line_valid);
  assign fin        = (remaining_reg == '0) && pad_placed_reg && !late_pad_reg;
  assign issue_fire = (state_reg == ISSUE) && core_ready;
  assign bitlen     = 64'({len_reg, 3'b000});
  assign busy       = (state_reg != IDLE);

  // Byte k: message data below the remaining count, 0x80 at the first free slot, else zero.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_byte
      localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
      assign half_next[511-8*gi -: 8] =
          (remaining_reg > IDX)                          ? line_data[8*gi +: 8] :
          ((remaining_reg == IDX) && !pad_placed_reg)    ? 8'h80 : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)       state_next = FILL0;
      FILL0:   if (advance)     state_next = FILL1;
      FILL1:   if (advance)     state_next = LEN;
      LEN:                      state_next = ISSUE;
      ISSUE:   if (core_ready)  state_next = WBUSY;
      WBUSY:   if (!core_ready) state_next = WRDY;
      WRDY:    if (core_ready)  state_next = final_reg ? IDLE : FILL0;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg         <= '0;
      remaining_reg   <= '0;
      pad_placed_reg  <= 1'b0;
      late_pad_reg    <= 1'b0;
      final_reg       <= 1'b0;
      work1_reg       <= '0;
      work0_reg       <= '0;
      block1_reg      <= '0;
      block0_reg      <= '0;
      block_valid_reg <= 1'b0;
      last_block_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg        <= msg_len;
            remaining_reg  <= msg_len;
            pad_placed_reg <= 1'b0;
            late_pad_reg   <= 1'b0;
            final_reg      <= 1'b0;
          end
        end
        FILL0, FILL1: begin
          if (advance) begin
            if (state_reg == FILL0) work1_reg <= half_next;
            else                    work0_reg <= half_next;
            remaining_reg  <= (remaining_reg > LINE_BYTES) ? remaining_reg - LINE_BYTES : '0;
            pad_placed_reg <= pad_placed_reg || (remaining_reg < LINE_BYTES);
            // Pad at block offset >= 112 leaves no room for the length field.
            if ((state_reg == FILL1) && (remaining_reg >= LATE_PAD) &&
                (remaining_reg < LINE_BYTES))
              late_pad_reg <= 1'b1;
          end
        end
        LEN: begin
          final_reg    <= fin;
          late_pad_reg <= 1'b0;
          if (fin) work0_reg[127:0] <= {64'h0, bitlen};
        end
        default: ;
      endcase

      block_valid_reg <= issue_fire;
      last_block_reg  <= issue_fire && final_reg;
      if (issue_fire) begin
        block1_reg <= work1_reg;
        block0_reg <= work0_reg;
      end
    end
  end

  assign block[1]    = block1_reg;
  assign block[0]    = block0_reg;
  assign block_valid = block_valid_reg;
  assign last_block  = last_block_reg;

`ifdef SHA512_PAD_STATS_EN
  logic [31:0] blk_count_reg, msg_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_count_reg <= '0;
      msg_count_reg <= '0;
    end else begin
      if (block_valid_reg) blk_count_reg <= blk_count_reg + 32'd1;
      if (last_block_reg)  msg_count_reg <= msg_count_reg + 32'd1;
    end
  end

  assign blk_count = blk_count_reg;
  assign msg_count = msg_count_reg;
`endif

endmodule

// File: tb/tb_sha512_pad.sv
// Randomized self-checking bench for sha512_pad against a byte-level FIPS 180-4 padding model.
// Models the hash wrapper's ready handshake and a line feeder with random valid gaps.
module tb_sha512_pad;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [31:0]  msg_len;
  logic [511:0] line_data;
  logic         line_valid;
  logic         line_ready;
  logic [511:0] block [2];
  logic         block_valid;
  logic         core_ready;
  logic         last_block;
  logic         busy;
`ifdef SHA512_PAD_STATS_EN
  logic [31:0]  blk_count, msg_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [511:0] last_b1, last_b0;

  always #5 clk = ~clk;

  sha512_pad #(.LEN_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
    .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
    .block(block), .block_valid(block_valid), .core_ready(core_ready),
    .last_block(last_block),
`ifdef SHA512_PAD_STATS_EN
    .blk_count(blk_count), .msg_count(msg_count),
`endif
    .busy(busy)
  );

  task automatic check_idle_outputs(input string name);
    logic [1:0] flags;
    total++;
    if ({line_ready, block_valid, last_block, busy} !== 4'b0 ||
        block[1] !== 512'h0 || block[0] !== 512'h0) begin
      bad++;
      flags = {block[1] != 512'h0, block[0] != 512'h0};
      $display("FAIL %s got rdy=%b vld=%b last=%b busy=%b blk_nz=%b exp all zero",
               name, line_ready, block_valid, last_block, busy, flags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; msg_len = '0; line_data = '0;
    line_valid = 1'b0; core_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  // mode 0: random bytes; mode 1: constant pat; mode 2: pat+i
  task automatic run_msg(input int L, input int hold, input int gap_pct,
                         input int mode, input logic [7:0] pat);
    logic [7:0]  msg[$];
    logic [7:0]  exp_q[$];
    logic [63:0] bl;
    logic [511:0] e1, e0;
    int nlines, nblk, li, bi, cyc, hold_left, drop_in, low_left, extra_acc;
    bit hs, done;

    for (int i = 0; i < L; i++)
      msg.push_back(mode == 0 ? 8'($urandom) : (mode == 1 ? pat : 8'(pat + i)));
    exp_q = msg;
    exp_q.push_back(8'h80);
    while ((exp_q.size() % 128) != 112) exp_q.push_back(8'h00);
    bl = 64'(L) << 3;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h00);
    for (int k = 0; k < 8; k++) exp_q.push_back(bl[63-8*k -: 8]);
    nlines = (L + 63) / 64;
    nblk   = exp_q.size() / 128;

    hold_left = hold; drop_in = 0; low_left = 0;
    li = 0; bi = 0; cyc = 0; hs = 0; done = 0; extra_acc = 0;

    @(negedge clk);
    start = 1'b1; msg_len = L;
    core_ready = (hold == 0);
    if (hold > 0) hold_left = hold - 1;
    @(negedge clk);
    start = 1'b0;

    while (!done && cyc < 4000) begin
      if (hs) begin
        if (li >= nlines) extra_acc++;
        li++;
      end
      if (block_valid) begin
        total++;
        if (core_ready !== 1'b1) begin
          bad++;
          $display("FAIL issue_ready L=%0d blk%0d got core_ready=%b exp 1", L, bi, core_ready);
        end
        if (bi >= nblk) begin
          total++; bad++;
          $display("FAIL extra_block L=%0d got blk%0d exp %0d blocks", L, bi, nblk);
        end else begin
          for (int j = 0; j < 64; j++) begin
            e1[511-8*j -: 8] = exp_q[128*bi + j];
            e0[511-8*j -: 8] = exp_q[128*bi + 64 + j];
          end
          total++;
          if (block[1] !== e1) begin
            bad++;
            $display("FAIL block1 L=%0d blk%0d got=%h exp=%h", L, bi, block[1], e1);
          end
          total++;
          if (block[0] !== e0) begin
            bad++;
            $display("FAIL block0 L=%0d blk%0d got=%h exp=%h", L, bi, block[0], e0);
          end
          total++;
          if (last_block !== (bi == nblk - 1)) begin
            bad++;
            $display("FAIL last_block L=%0d blk%0d got=%b exp=%b", L, bi, last_block, bi == nblk - 1);
          end
        end
        last_b1 = block[1];
        last_b0 = block[0];
        bi++;
        drop_in = 1;
      end
      // Wrapper model: ready stays up one more cycle after the pulse, then drops a while.
      if (hold_left > 0) begin
        core_ready = 1'b0; hold_left--;
      end else if (drop_in > 0) begin
        drop_in--; core_ready = 1'b1;
        if (drop_in == 0) low_left = 1 + $urandom_range(0, 4);
      end else if (low_left > 0) begin
        core_ready = 1'b0; low_left--;
      end else begin
        core_ready = 1'b1;
      end
      line_valid = ($urandom_range(0, 99) >= gap_pct);
      for (int j = 0; j < 64; j++)
        line_data[8*j +: 8] = (64*li + j < L) ? msg[64*li + j] : 8'($urandom);
      hs = line_valid && line_ready;
      done = (bi >= nblk) && !busy;
      @(negedge clk);
      cyc++;
    end
    line_valid = 1'b0;
    core_ready = 1'b1;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL timeout L=%0d got blocks=%0d exp %0d", L, bi, nblk);
    end
    total++;
    if (li - extra_acc != nlines || extra_acc != 0) begin
      bad++;
      $display("FAIL lines L=%0d got accepted=%0d extra=%0d exp %0d", L, li, extra_acc, nlines);
    end
    repeat (3) @(negedge clk);
    total++;
    if (block_valid !== 1'b0 || busy !== 1'b0 || line_ready !== 1'b0) begin
      bad++;
      $display("FAIL after_msg L=%0d got vld=%b busy=%b rdy=%b exp 0", L, block_valid, busy, line_ready);
    end
    $display("msg L=%0d blocks=%0d lines=%0d cycles=%0d", L, bi, li, cyc);
  endtask

  task automatic test_directed();
    run_msg(0, 0, 0, 1, 8'h00);
    total++;
    if (last_b1 !== {8'h80, 504'h0} || last_b0 !== 512'h0) begin
      bad++;
      $display("FAIL len0 got b1=%h b0=%h exp 80.. and 0", last_b1, last_b0);
    end
    run_msg(3, 0, 0, 2, 8'h61);
    total++;
    if (last_b1[511:480] !== 32'h61626380 || last_b0[127:0] !== 128'h18) begin
      bad++;
      $display("FAIL abc got head=%h lenf=%h exp 61626380 18", last_b1[511:480], last_b0[127:0]);
    end
    run_msg(112, 0, 30, 1, 8'hAA);
    total++;
    if (last_b1 !== 512'h0 || last_b0[127:0] !== 128'h380 || last_b0[511:128] !== '0) begin
      bad++;
      $display("FAIL len112 got lenf=%h exp 380", last_b0[127:0]);
    end
    run_msg(128, 0, 30, 0, 8'h00);
    total++;
    if (last_b1[511:504] !== 8'h80 || last_b0[127:0] !== 128'h400) begin
      bad++;
      $display("FAIL len128 got head=%h lenf=%h exp 80 400", last_b1[511:504], last_b0[127:0]);
    end
  endtask

  task automatic test_stall();
    run_msg(3, 20, 50, 0, 8'h00);
    run_msg(200, 20, 50, 0, 8'h00);
  endtask

  task automatic test_boundaries();
    int lens[12] = '{1, 55, 63, 64, 65, 111, 113, 127, 129, 239, 240, 256};
    foreach (lens[i]) run_msg(lens[i], 0, 25, 0, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) run_msg($urandom_range(0, 420), $urandom_range(0, 3), 40, 0, 8'h00);
  endtask

  task automatic test_abort();
    int n = 0;
    @(negedge clk);
    start = 1'b1; msg_len = 150;
    @(negedge clk);
    start = 1'b0; line_valid = 1'b1;
    for (int j = 0; j < 16; j++) line_data[32*j +: 32] = $urandom;
    while (!(line_valid && line_ready) && n < 20) begin
      @(negedge clk); n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL abort_accept got no line_ready exp accept");
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_reset");
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (block_valid || line_ready || busy) n++;
    end
    line_valid = 1'b0;
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", n);
    end
    run_msg(3, 0, 0, 2, 8'h61);
    total++;
    if (last_b1[511:480] !== 32'h61626380 || last_b0[127:0] !== 128'h18) begin
      bad++;
      $display("FAIL abort_abc got head=%h lenf=%h exp 61626380 18", last_b1[511:480], last_b0[127:0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_boundaries();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
